// File: rtl/stall_ctrl.sv
// Hazard and stall controller for the 5-stage F/D/E/M/W pipeline.
// Decodes the D/E/M instructions, compares the source registers of instr_D
// against the destinations A3_E/A3_M using Tuse/Tnew timing, and sequences
// the multi-cycle mult/div unit that lives in E.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr_D/E/M           instructions held in REG_D/REG_E/REG_M
//   A3_E, A3_M            destination registers of instr_E/instr_M (0 = none)
//   pc_en, d_en           PC and REG_D write enables (low while stalled)
//   e_clr                 REG_E clear, inserts a bubble while stalled
//   md_start              mult/div unit latches operands this cycle
//   md_busy               mult/div unit still computing
//   stall_cnt             stalled cycles since reset, saturating
module stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] instr_M,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam int unsigned CW = 4;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  logic [5:0] op_d, fn_d, op_e, fn_e, op_m;
  logic [4:0] rs_d, rt_d;

  assign op_d = instr_D[31:26];
  assign fn_d = instr_D[5:0];
  assign rs_d = instr_D[25:21];
  assign rt_d = instr_D[20:16];
  assign op_e = instr_E[31:26];
  assign fn_e = instr_E[5:0];
  assign op_m = instr_M[31:26];

  // Immediate/offset fields never take part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^{instr_D[15:6], instr_E[25:6], instr_M[25:0]};

  logic       rs_used, rt_used, md_d;
  logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;

  // Source-operand timing and MD class of instr_D.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    tuse_rs = 2'd0;
    tuse_rt = 2'd0;
    md_d    = 1'b0;
    case (op_d)
      OP_SPECIAL: begin
        case (fn_d)
          FN_ADDU, FN_SUBU: begin
            rs_used = 1'b1; tuse_rs = 2'd1;
            rt_used = 1'b1; tuse_rt = 2'd1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            rs_used = 1'b1; tuse_rs = 2'd1;
            rt_used = 1'b1; tuse_rt = 2'd1;
            md_d    = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            rs_used = 1'b1; tuse_rs = 2'd1;
            md_d    = 1'b1;
          end
          FN_MFHI, FN_MFLO: md_d = 1'b1;
          FN_JR: begin
            rs_used = 1'b1; tuse_rs = 2'd0;
          end
          default: ;
        endcase
      end
      OP_BEQ: begin
        rs_used = 1'b1; tuse_rs = 2'd0;
        rt_used = 1'b1; tuse_rt = 2'd0;
      end
      OP_ORI, OP_LW: begin
        rs_used = 1'b1; tuse_rs = 2'd1;
      end
      OP_SW: begin
        rs_used = 1'b1; tuse_rs = 2'd1;
        rt_used = 1'b1; tuse_rt = 2'd2;
      end
      default: ;
    endcase
  end

  // Cycles until the result of instr_E / instr_M is forwardable.
  always_comb begin
    tnew_e = 2'd0;
    case (op_e)
      OP_SPECIAL: begin
        case (fn_e)
          FN_ADDU, FN_SUBU, FN_MFHI, FN_MFLO: tnew_e = 2'd1;
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: tnew_e = 2'd1;
      OP_LW:          tnew_e = 2'd2;
      OP_JAL:         tnew_e = 2'd0;
      default: ;
    endcase
  end

  assign tnew_m = (op_m == OP_LW) ? 2'd1 : 2'd0;

  logic stall_rs, stall_rt, data_stall, md_stall, stall, md_mult_e;

  // $0 is hardwired, so it is never a real dependency.
  assign stall_rs = rs_used && (rs_d != 5'd0) &&
                    (((rs_d == A3_E) && (tuse_rs < tnew_e)) ||
                     ((rs_d == A3_M) && (tuse_rs < tnew_m)));
  assign stall_rt = rt_used && (rt_d != 5'd0) &&
                    (((rt_d == A3_E) && (tuse_rt < tnew_e)) ||
                     ((rt_d == A3_M) && (tuse_rt < tnew_m)));
  assign data_stall = stall_rs || stall_rt;

  assign md_mult_e = (op_e == OP_SPECIAL) && ((fn_e == FN_MULT) || (fn_e == FN_MULTU));
  assign md_start  = (op_e == OP_SPECIAL) &&
                     ((fn_e == FN_MULT) || (fn_e == FN_MULTU) ||
                      (fn_e == FN_DIV)  || (fn_e == FN_DIVU));

  logic [CW-1:0] cnt;

  // Remaining busy cycles of the mult/div unit.
  always_ff @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (md_start)       cnt <= md_mult_e ? CW'(MULT_CYC) : CW'(DIV_CYC);
    else if (cnt != '0)      cnt <= cnt - CW'(1);
  end

  assign md_busy  = (cnt != '0);
  assign md_stall = md_d && (md_start || md_busy);
  assign stall    = data_stall || md_stall;

  assign pc_en = !stall;
  assign d_en  = !stall;
  assign e_clr = stall;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset)                                 stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed hazard scenarios plus a
// randomized phase, all compared against a mnemonic-level timing model.
module tb_stall_ctrl;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;

  typedef enum int {NOP, ADDU, SUBU, ORI, LUI, LW, SW, BEQ, JR, JAL,
                    MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO} mn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, instr_E, instr_M;
  logic [4:0]  A3_E, A3_M;
  logic        pc_en, d_en, e_clr, md_start, md_busy;
  logic [31:0] stall_cnt;

  stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset),
    .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .A3_E(A3_E), .A3_M(A3_M),
    .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state: what the pipeline holds, plus busy cycles left and stall total.
  mn_t         m_d, m_e, m_m;
  logic [4:0]  m_rs, m_rt, m_a3e, m_a3m;
  logic        m_rst;
  int          busy_left = 0;
  logic [31:0] sc = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(mn_t m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    case (m)
      ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      ORI:   return {6'h0D, rs, rd, 16'h00F0};
      LUI:   return {6'h0F, 5'd0, rd, 16'h1234};
      LW:    return {6'h23, rs, rd, 16'h0004};
      SW:    return {6'h2B, rs, rt, 16'h0008};
      BEQ:   return {6'h04, rs, rt, 16'hFFFC};
      JR:    return {6'h00, rs, 15'd0, 6'h08};
      JAL:   return {6'h03, 26'h0000040};
      MULT:  return {6'h00, rs, rt, 10'd0, 6'h18};
      MULTU: return {6'h00, rs, rt, 10'd0, 6'h19};
      DIV:   return {6'h00, rs, rt, 10'd0, 6'h1A};
      DIVU:  return {6'h00, rs, rt, 10'd0, 6'h1B};
      MFHI:  return {6'h00, 10'd0, rd, 5'd0, 6'h10};
      MFLO:  return {6'h00, 10'd0, rd, 5'd0, 6'h12};
      MTHI:  return {6'h00, rs, 15'd0, 6'h11};
      MTLO:  return {6'h00, rs, 15'd0, 6'h13};
      default: return 32'h0;
    endcase
  endfunction

  // Stage at which each source is needed; -1 = not a source.
  function automatic int tuse_rs(mn_t m);
    case (m)
      BEQ, JR: return 0;
      ADDU, SUBU, ORI, LW, SW, MULT, MULTU, DIV, DIVU, MTHI, MTLO: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int tuse_rt(mn_t m);
    case (m)
      BEQ: return 0;
      ADDU, SUBU, MULT, MULTU, DIV, DIVU: return 1;
      SW: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int tnew_e(mn_t m);
    case (m)
      LW: return 2;
      ADDU, SUBU, ORI, LUI, MFHI, MFLO: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int tnew_m(mn_t m);
    return (m == LW) ? 1 : 0;
  endfunction

  function automatic bit is_md(mn_t m);
    return m inside {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO};
  endfunction

  function automatic bit hazard(logic [4:0] src, int tu);
    if (tu < 0 || src == 5'd0) return 1'b0;
    return ((src == m_a3e) && (tu < tnew_e(m_e))) || ((src == m_a3m) && (tu < tnew_m(m_m)));
  endfunction

  // Apply one cycle of inputs at the falling edge and let them settle.
  task automatic set_in(input mn_t md, input logic [4:0] rs, input logic [4:0] rt,
                        input mn_t me, input mn_t mm, input logic [4:0] a3e,
                        input logic [4:0] a3m, input logic rst);
    m_d = md; m_e = me; m_m = mm; m_rs = rs; m_rt = rt;
    m_a3e = a3e; m_a3m = a3m; m_rst = rst;
    instr_D = enc(md, rs, rt, 5'd9);
    instr_E = enc(me, 5'd6, 5'd7, a3e);
    instr_M = enc(mm, 5'd6, 5'd7, a3m);
    A3_E = a3e; A3_M = a3m; reset = rst;
    #1;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    bit start, busy, stall;
    start = m_e inside {MULT, MULTU, DIV, DIVU};
    busy  = (busy_left != 0);
    stall = hazard(m_rs, tuse_rs(m_d)) || hazard(m_rt, tuse_rt(m_d)) ||
            (is_md(m_d) && (start || busy));
    check("pc_en",     32'(pc_en),    32'(!stall));
    check("d_en",      32'(d_en),     32'(!stall));
    check("e_clr",     32'(e_clr),    32'(stall));
    check("md_start",  32'(md_start), 32'(start));
    check("md_busy",   32'(md_busy),  32'(busy));
    check("stall_cnt", stall_cnt,     sc);
    @(posedge clk);
    if (m_rst) begin
      busy_left = 0;
      sc = 32'd0;
    end else begin
      if (stall && sc != 32'hFFFF_FFFF) sc = sc + 32'd1;
      if (start) busy_left = (m_e inside {MULT, MULTU}) ? int'(MULT_CYC) : int'(DIV_CYC);
      else if (busy_left > 0) busy_left--;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(NOP, 5'd0, 5'd0, NOP, NOP, 5'd0, 5'd0, 1'b1);
    tick();
  endtask

  initial begin
    int hi, st;
    // Bring the design out of its unknown power-up state.
    set_in(NOP, 5'd0, 5'd0, NOP, NOP, 5'd0, 5'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd1);

    // lw $1 in E, addu $2,$1,$3 in D: one load-use bubble.
    set_in(ADDU, 5'd1, 5'd3, LW, NOP, 5'd1, 5'd0, 1'b0);
    check("lw_use_stall", 32'(e_clr), 32'd1);
    tick();
    set_in(ADDU, 5'd1, 5'd3, NOP, LW, 5'd0, 5'd1, 1'b0);
    check("lw_use_resolved", 32'(pc_en), 32'd1);
    tick();
    check("lw_use_count", stall_cnt, 32'd1);

    // beq $1,$2 against E and M producers.
    set_in(BEQ, 5'd1, 5'd2, ADDU, NOP, 5'd1, 5'd0, 1'b0);
    check("beq_e_addu", 32'(e_clr), 32'd1);
    tick();
    set_in(BEQ, 5'd1, 5'd2, NOP, LW, 5'd0, 5'd2, 1'b0);
    check("beq_m_lw", 32'(e_clr), 32'd1);
    tick();
    set_in(BEQ, 5'd1, 5'd2, NOP, ADDU, 5'd0, 5'd1, 1'b0);
    check("beq_m_addu", 32'(e_clr), 32'd0);
    tick();

    // sw $5,0($4): store data needed late, base needed early.
    set_in(SW, 5'd4, 5'd5, LW, NOP, 5'd5, 5'd0, 1'b0);
    check("sw_rt_lw", 32'(e_clr), 32'd0);
    tick();
    set_in(SW, 5'd4, 5'd5, LW, NOP, 5'd4, 5'd0, 1'b0);
    check("sw_rs_lw", 32'(e_clr), 32'd1);
    tick();

    // $0 and jal never cause stalls.
    set_in(ADDU, 5'd0, 5'd0, ADDU, NOP, 5'd0, 5'd0, 1'b0);
    check("zero_reg", 32'(e_clr), 32'd0);
    tick();
    set_in(JR, 5'd31, 5'd0, JAL, NOP, 5'd31, 5'd0, 1'b0);
    check("jal_jr", 32'(e_clr), 32'd0);
    tick();

    // mult in E, mfhi in D: start cycle plus MULT_CYC busy cycles.
    do_reset();
    hi = 0; st = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(MFHI, 5'd0, 5'd0, (i == 0) ? MULT : NOP, NOP, 5'd0, 5'd0, 1'b0);
      hi += int'(md_busy);
      st += int'(e_clr);
      if (i == 6) check("mult_release", 32'(pc_en), 32'd1);
      tick();
      if (i == 6) break;
    end
    set_in(NOP, 5'd0, 5'd0, MFHI, NOP, 5'd10, 5'd0, 1'b0);
    tick();
    check("mult_busy_cycles", 32'(hi), 32'(MULT_CYC));
    check("mult_stall_cycles", 32'(st), 32'(MULT_CYC + 1));
    check("mult_stall_cnt", stall_cnt, 32'(MULT_CYC + 1));

    // div in E, mflo in D: start cycle plus DIV_CYC busy cycles.
    do_reset();
    st = 0;
    for (int i = 0; i < 12; i++) begin
      set_in(MFLO, 5'd0, 5'd0, (i == 0) ? DIV : NOP, NOP, 5'd0, 5'd0, 1'b0);
      st += int'(e_clr);
      tick();
    end
    check("div_stall_cycles", 32'(st), 32'(DIV_CYC + 1));

    // Independent addu during busy, then reset with cnt = 4.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        set_in(ADDU, 5'd5, 5'd6, NOP, NOP, 5'd0, 5'd0, 1'b0);
        check("addu_during_busy", 32'(e_clr), 32'd0);
      end else if (i == 7) begin
        set_in(ADDU, 5'd5, 5'd6, NOP, NOP, 5'd0, 5'd0, 1'b1);
      end else begin
        set_in(MFLO, 5'd0, 5'd0, (i == 0) ? DIVU : NOP, NOP, 5'd0, 5'd0, 1'b0);
      end
      tick();
    end
    set_in(MFLO, 5'd0, 5'd0, NOP, NOP, 5'd0, 5'd0, 1'b0);
    check("reset_abandon_busy", 32'(md_busy), 32'd0);
    check("reset_abandon_cnt", stall_cnt, 32'd0);
    tick();

    // Saturation: preload near the top, then keep stalling.
    do_reset();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    set_in(ADDU, 5'd1, 5'd3, LW, NOP, 5'd1, 5'd0, 1'b0);
    release dut.stall_cnt;
    sc = 32'hFFFF_FFFE;
    repeat (3) tick();
    check("saturate", stall_cnt, 32'hFFFF_FFFF);

    // Randomized traffic; an MD op only enters E when the unit is idle.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mn_t md, me, mm;
      logic r;
      r  = ($urandom_range(0, 39) == 0);
      md = mn_t'($urandom_range(0, 17));
      me = mn_t'($urandom_range(0, 17));
      mm = mn_t'($urandom_range(0, 17));
      if ((busy_left != 0 || r) && (me inside {MULT, MULTU, DIV, DIVU})) me = NOP;
      if (r && is_md(md)) md = NOP;
      set_in(md, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), me, mm,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
